// File: rtl/imem_if.sv
// Fetch and program-load bus between the core fetch path and imem_responder.
interface imem_if #(
    parameter int ADDR_W = 8
);
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [31:0]       fetch_instr;
    logic              fetch_err;
    logic              load_en;
    logic              load_valid;
    logic [7:0]        load_byte;
    logic              load_ready;
    logic              load_done;
    logic [ADDR_W:0]   load_count;

    modport master (
        output fetch_req, fetch_addr,
        output load_en, load_valid, load_byte,
        input  fetch_ready, fetch_valid, fetch_instr, fetch_err,
        input  load_ready, load_done, load_count
    );

    modport slave (
        input  fetch_req, fetch_addr,
        input  load_en, load_valid, load_byte,
        output fetch_ready, fetch_valid, fetch_instr, fetch_err,
        output load_ready, load_done, load_count
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency word fetch with error flagging,
// plus a byte-serial big-endian program-load port.
module imem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic   clk,
    input  logic   rst,
    imem_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, LOAD} state_t;

    state_t              state;
    state_t              state_nx;
    logic [3:0]          cnt;
    logic [ADDR_W-1:0]   idx_q;
    logic                err_q;
    logic                ready_q;
    logic [1:0]          bptr;
    logic [23:0]         asm_q;
    logic [31:0]         mem [DEPTH];

    logic                accept;
    logic                addr_bad;
    logic                byte_take;
    logic                word_wr;
    logic                full;
    logic                err_now;
    logic [ADDR_W-1:0]   rd_idx;
    logic [31:0]         rd_word;

    assign addr_bad = (bus.fetch_addr[1:0] != 2'b00) ||
                      ((bus.fetch_addr >> (ADDR_W + 2)) != 32'd0);
    assign full     = bus.load_count[ADDR_W];

    // ready_q tracks "in IDLE" but stays low for the first cycle after reset
    assign bus.fetch_ready = ready_q & ~bus.load_en;

    // Zero-wait and error responses read the live address in IDLE
    assign rd_idx  = (state == IDLE) ? bus.fetch_addr[ADDR_W+1:2] : idx_q;
    assign rd_word = mem[rd_idx];
    assign err_now = (state == IDLE) ? addr_bad : err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        accept         = 1'b0;
        byte_take      = 1'b0;
        word_wr        = 1'b0;
        bus.load_ready = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.load_en) begin
                    state_nx = LOAD;
                end else if (bus.fetch_req && ready_q) begin
                    accept   = 1'b1;
                    state_nx = (addr_bad || WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            LOAD: begin
                bus.load_ready = bus.load_en & ~full;
                byte_take      = bus.load_ready & bus.load_valid;
                word_wr        = byte_take && (bptr == 2'd3);
                if (!bus.load_en) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q         <= 1'b0;
            cnt             <= 4'd0;
            idx_q           <= '0;
            err_q           <= 1'b0;
            bptr            <= 2'd0;
            asm_q           <= 24'd0;
            bus.fetch_valid <= 1'b0;
            bus.fetch_instr <= 32'd0;
            bus.fetch_err   <= 1'b0;
            bus.load_done   <= 1'b0;
            bus.load_count  <= '0;
        end else begin
            ready_q         <= (state_nx == IDLE);
            bus.fetch_valid <= (state_nx == RESP);
            bus.fetch_err   <= (state_nx == RESP) && err_now;
            bus.load_done   <= (state == LOAD) && (state_nx == IDLE);
            if (accept) begin
                idx_q <= bus.fetch_addr[ADDR_W+1:2];
                err_q <= addr_bad;
                cnt   <= 4'(WAIT_STATES - 1);
            end
            if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (state_nx == RESP) begin
                bus.fetch_instr <= err_now ? 32'd0 : rd_word;
            end
            if (state == IDLE && state_nx == LOAD) begin
                bus.load_count <= '0;
                bptr           <= 2'd0;
            end
            if (byte_take) begin
                asm_q <= {asm_q[15:0], bus.load_byte};
                bptr  <= bptr + 2'd1;
                if (word_wr) begin
                    bus.load_count <= bus.load_count + 1'b1;
                end
            end
        end
    end

    // Storage is deliberately left out of reset so programs survive it
    always_ff @(posedge clk) begin
        if (word_wr) begin
            mem[bus.load_count[ADDR_W-1:0]] <= {asm_q, bus.load_byte};
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: directed load/fetch vectors,
// monitor compares every fetch_valid against queued expectations.
module tb_imem_responder;
    localparam int ADDR_W = 8;
    localparam int WS     = 1;
    localparam int DEPTH  = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    imem_if #(.ADDR_W(ADDR_W)) bus ();

    imem_responder #(
        .ADDR_W(ADDR_W),
        .WAIT_STATES(WS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] instr;
        logic        err;
        int          at;
    } exp_t;

    exp_t sb[$];
    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int done_cnt  = 0;

    always @(posedge clk) cyc++;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endfunction

    function automatic logic [31:0] pat(int i);
        return {8'hC0, i[7:0], 8'h5A, ~i[7:0]};
    endfunction

    exp_t e;
    always @(negedge clk) begin
        if (bus.load_done) done_cnt++;
        if (rst && bus.fetch_valid) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_valid: got fetch_valid instr=%h at cycle %0d, required none",
                         bus.fetch_instr, cyc);
            end else begin
                e = sb.pop_front();
                check("fetch_instr", 64'(bus.fetch_instr), 64'(e.instr));
                check("fetch_err", 64'(bus.fetch_err), 64'(e.err));
                check("fetch_latency", 64'(cyc), 64'(e.at));
            end
        end
    end

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] ins,
                            input logic er, input bit push, output int t);
        int k;
        @(negedge clk);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = a;
        k = 0;
        while (!bus.fetch_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.fetch_ready) begin
            total_cnt++;
            $display("FAIL fetch_ready_timeout: got ready=0 for addr %h, required 1", a);
            bus.fetch_req = 1'b0;
            t = -1;
            return;
        end
        @(posedge clk);
        #1;
        t = cyc;
        bus.fetch_req = 1'b0;
        if (push) sb.push_back('{ins, er, t + (er ? 0 : WS)});
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] ins, input logic er);
        int t;
        do_fetch(a, ins, er, 1'b1, t);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        bus.load_valid = 1'b1;
        bus.load_byte  = b;
        k = 0;
        @(negedge clk);
        while (!bus.load_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.load_ready) begin
            total_cnt++;
            $display("FAIL load_ready_timeout: got ready=0 for byte %h, required 1", b);
        end else begin
            @(posedge clk);
            #1;
        end
        bus.load_valid = 1'b0;
    endtask

    task automatic begin_load();
        @(negedge clk);
        bus.load_en = 1'b1;
    endtask

    task automatic end_load(input int exp_count);
        int d0;
        d0 = done_cnt;
        @(negedge clk);
        bus.load_en = 1'b0;
        repeat (3) @(negedge clk);
        check("load_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("load_count", 64'(bus.load_count), 64'(exp_count));
    endtask

    task automatic drain();
        repeat (WS + 4) @(negedge clk);
    endtask

    task automatic check_zero(string name);
        check(name, {bus.fetch_valid, bus.fetch_ready, bus.fetch_err,
                     bus.load_ready, bus.load_done, 9'(bus.load_count)}, 64'd0);
        check({name, "_instr"}, 64'(bus.fetch_instr), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1;
        int t2;
        logic [7:0] prog [8];
        logic [31:0] w;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = 32'd0;
        bus.load_en    = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_byte  = 8'd0;

        #2;
        check_zero("reset_outputs");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("ready_after_release", 64'(bus.fetch_ready), 64'd0);
        @(posedge clk);
        #1;
        check("ready_first_clock", 64'(bus.fetch_ready), 64'd1);

        prog = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h01};
        begin_load();
        for (int i = 0; i < 8; i++) send_byte(prog[i]);
        end_load(2);

        fetch(32'h0, 32'hDEADBEEF, 1'b0);
        do_fetch(32'h4, 32'h00000001, 1'b0, 1'b1, t1);
        do_fetch(32'h0, 32'hDEADBEEF, 1'b0, 1'b1, t2);
        check("back_to_back_spacing", 64'(t2 - t1), 64'(2 + WS));
        drain();

        fetch(32'h6, 32'h0, 1'b1);
        fetch(32'h400, 32'h0, 1'b1);
        fetch(32'h1, 32'h0, 1'b1);
        drain();

        begin_load();
        for (int i = 0; i < DEPTH; i++) begin
            w = pat(i);
            send_byte(w[31:24]);
            send_byte(w[23:16]);
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
        @(negedge clk);
        check("full_count", 64'(bus.load_count), 64'(DEPTH));
        bus.load_valid = 1'b1;
        bus.load_byte  = 8'h77;
        for (int i = 0; i < 4; i++) begin
            check("full_ready", 64'(bus.load_ready), 64'd0);
            @(negedge clk);
        end
        bus.load_valid = 1'b0;
        end_load(DEPTH);

        fetch(32'h3FC, pat(255), 1'b0);
        fetch(32'h200, pat(128), 1'b0);
        fetch(32'h0, pat(0), 1'b0);
        drain();

        begin_load();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        end_load(1);
        fetch(32'h0, 32'h11223344, 1'b0);
        fetch(32'h4, pat(1), 1'b0);
        drain();

        @(negedge clk);
        bus.load_en    = 1'b1;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h0;
        #1;
        check("collision_ready", 64'(bus.fetch_ready), 64'd0);
        @(negedge clk);
        check("collision_in_load", 64'(bus.load_ready), 64'd1);
        repeat (2) @(negedge clk);
        bus.fetch_req = 1'b0;
        end_load(0);
        fetch(32'h0, 32'h11223344, 1'b0);
        drain();

        do_fetch(32'h4, 32'h0, 1'b0, 1'b0, t1);
        rst = 1'b0;
        #1;
        check_zero("reset_mid_wait");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("ready_after_rerelease", 64'(bus.fetch_ready), 64'd0);
        @(posedge clk);
        #1;
        check("ready_after_reset", 64'(bus.fetch_ready), 64'd1);
        drain();
        fetch(32'h4, pat(1), 1'b0);
        drain();

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
